// File: rtl/branch_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp_pkg
// Description : Shared types for the serial branch-compare unit: condition
//               code encoding, FSM state encoding and flag bit positions.
// Revision    : 1.0  initial release
// ============================================================================
package branch_cmp_pkg;

    typedef enum logic [3:0] {
        COND_EQ     = 4'd0,
        COND_NE     = 4'd1,
        COND_GT     = 4'd2,
        COND_LT     = 4'd3,
        COND_RDZ    = 4'd4,
        COND_RDNEG  = 4'd5,
        COND_RDONES = 4'd6,
        COND_GEU    = 4'd7,
        COND_LTU    = 4'd8,
        COND_GTU    = 4'd9,
        COND_ALWAYS = 4'd10
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit positions inside the {Z,N,C,V} flag vector
    localparam int Z_B = 3;
    localparam int N_B = 2;
    localparam int C_B = 1;
    localparam int V_B = 0;

endpackage
`default_nettype wire

// File: rtl/cmp_slice.sv
`default_nettype none
// ============================================================================
// Module      : cmp_slice
// Description : One SLICE-bit step of A - B, computed as A + ~B + cin.
//   a, b    : operand slices
//   cin     : carry in (1 on the first slice, i.e. no borrow)
//   diff    : difference slice
//   cout    : carry out (1 = no borrow out of this slice)
//   is_zero : diff is all zeros
// Revision    : 1.0  initial release
// ============================================================================
module cmp_slice
    import branch_cmp_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] diff,
    output logic             cout,
    output logic             is_zero
);

    logic [SLICE:0] w_sum;

    assign w_sum   = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, cin};
    assign diff    = w_sum[SLICE-1:0];
    assign cout    = w_sum[SLICE];
    assign is_zero = (w_sum[SLICE-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/branch_compare_seq.sv
`default_nettype none
// ============================================================================
// Module      : branch_compare_seq
// Description : Multi-cycle branch-condition unit. Computes Rd - B serially,
//               SLICE bits per cycle LSB first, accumulates Z/N/C/V and
//               resolves a 4-bit condition code into a registered jump.
// Ports       :
//   clk, reset            clock, synchronous active-high reset
//   start / ready         request / unit idle (start honoured only if ready)
//   r_or_i                1: B = n_imm, 0: B = rs_data
//   cmp_or_sub            1: SUB mode, jump = (alu_out == 0)
//   cond                  condition code (cond_e)
//   rd_data, rs_data,
//   n_imm, alu_out        operands / ALU result
//   done                  one-cycle pulse, jump/flags updated this cycle
//   jump, flags           branch decision and {Z,N,C,V}, held between dones
// Config      : define CMP_SIGNED_OVF_EN for a true signed LT (N ^ V) and a
//               real V flag; otherwise LT = N and V reads 0.
// Revision    : 1.0  initial release
// ============================================================================
module branch_compare_seq
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic             r_or_i,
    input  logic             cmp_or_sub,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] n_imm,
    input  logic [WIDTH-1:0] alu_out,
    output logic             done,
    output logic             jump,
    output logic [3:0]       flags
);

    localparam int c_nsl   = WIDTH / SLICE;
    localparam int c_idx_w = (c_nsl > 1) ? $clog2(c_nsl) : 1;

    generate
        if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
            $error("branch_compare_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    state_e             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    cond_e              r_cond;
    logic               r_sub;
    logic               r_hold;      // SUB ops spend one extra cycle in DONE
    logic               r_sub_zero;
    logic [c_idx_w-1:0] r_idx;
    logic               r_carry;
    logic               r_zacc;
    logic               r_rdz;
    logic               r_rdo;
    logic               r_n;
    logic               r_ready;
    logic               r_done;
    logic               r_jump;
    logic [3:0]         r_flags;

    logic [SLICE-1:0]   w_a_s;
    logic [SLICE-1:0]   w_b_s;
    logic [SLICE-1:0]   w_diff;
    logic               w_cout;
    logic               w_is_zero;
    logic               w_last;
    logic               w_lt;
    logic               w_v;
    logic               w_jump_cmp;
    logic [3:0]         w_flags_new;
    logic               w_unused_diff;

    // One slice adder, time-multiplexed over the slice index
    assign w_a_s  = r_a[int'(r_idx)*SLICE +: SLICE];
    assign w_b_s  = r_b[int'(r_idx)*SLICE +: SLICE];
    assign w_last = (r_idx == c_idx_w'(c_nsl - 1));

    cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a       (w_a_s),
        .b       (w_b_s),
        .cin     (r_carry),
        .diff    (w_diff),
        .cout    (w_cout),
        .is_zero (w_is_zero)
    );

    // Only the top bit of each difference slice is kept; zero comes from is_zero
    assign w_unused_diff = ^w_diff;

`ifdef CMP_SIGNED_OVF_EN
    logic r_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_v <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_diff[SLICE-1]);
        end
    end

    assign w_v  = r_v;
    assign w_lt = r_n ^ r_v;
`else
    assign w_v  = 1'b0;
    assign w_lt = r_n;
`endif

    always_comb begin
        w_flags_new      = 4'b0000;
        w_flags_new[Z_B] = r_zacc;
        w_flags_new[N_B] = r_n;
        w_flags_new[C_B] = r_carry;
        w_flags_new[V_B] = w_v;
    end

    // Accumulators are final while in DONE after the last slice
    always_comb begin
        w_jump_cmp = 1'b0;
        case (r_cond)
            COND_EQ:     w_jump_cmp = r_zacc;
            COND_NE:     w_jump_cmp = ~r_zacc;
            COND_GT:     w_jump_cmp = ~r_zacc & ~w_lt;
            COND_LT:     w_jump_cmp = w_lt;
            COND_RDZ:    w_jump_cmp = r_rdz;
            COND_RDNEG:  w_jump_cmp = r_a[WIDTH-1];
            COND_RDONES: w_jump_cmp = r_rdo;
            COND_GEU:    w_jump_cmp = r_carry;
            COND_LTU:    w_jump_cmp = ~r_carry;
            COND_GTU:    w_jump_cmp = r_carry & ~r_zacc;
            COND_ALWAYS: w_jump_cmp = 1'b1;
            default:     w_jump_cmp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_jump     <= 1'b0;
            r_flags    <= 4'b0000;
            r_a        <= '0;
            r_b        <= '0;
            r_cond     <= COND_EQ;
            r_sub      <= 1'b0;
            r_hold     <= 1'b0;
            r_sub_zero <= 1'b0;
            r_idx      <= '0;
            r_carry    <= 1'b1;
            r_zacc     <= 1'b1;
            r_rdz      <= 1'b1;
            r_rdo      <= 1'b1;
            r_n        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a        <= rd_data;
                        r_b        <= r_or_i ? n_imm : rs_data;
                        r_cond     <= cond_e'(cond);
                        r_sub      <= cmp_or_sub;
                        r_sub_zero <= (alu_out == '0);
                        r_idx      <= '0;
                        r_carry    <= 1'b1;
                        r_zacc     <= 1'b1;
                        r_rdz      <= 1'b1;
                        r_rdo      <= 1'b1;
                        r_ready    <= 1'b0;
                        if (cmp_or_sub) begin
                            r_hold  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_hold  <= 1'b0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_carry <= w_cout;
                    r_zacc  <= r_zacc & w_is_zero;
                    r_rdz   <= r_rdz & (w_a_s == '0);
                    r_rdo   <= r_rdo & (&w_a_s);
                    if (w_last) begin
                        r_n     <= w_diff[SLICE-1];
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                        if (r_sub) begin
                            r_jump <= r_sub_zero;
                        end else begin
                            r_jump  <= w_jump_cmp;
                            r_flags <= w_flags_new;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign jump  = r_jump;
    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_branch_compare_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_compare_seq
// Description : Scoreboard testbench for branch_compare_seq (WIDTH=16,
//               SLICE=4). Expected results are queued when an op is issued
//               and compared when done pulses; jump/flags are also checked
//               for stability on every non-done cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_compare_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic        r_or_i;
    logic        cmp_or_sub;
    logic [3:0]  cond;
    logic [15:0] rd_data;
    logic [15:0] rs_data;
    logic [15:0] n_imm;
    logic [15:0] alu_out;
    logic        done;
    logic        jump;
    logic [3:0]  flags;

    typedef struct {
        int         cyc;
        logic       jump;
        logic [3:0] flags;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic       hold_jump  = 1'b0;
    logic [3:0] hold_flags = 4'b0000;
    logic [3:0] sb_flags   = 4'b0000;

    branch_compare_seq #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .r_or_i     (r_or_i),
        .cmp_or_sub (cmp_or_sub),
        .cond       (cond),
        .rd_data    (rd_data),
        .rs_data    (rs_data),
        .n_imm      (n_imm),
        .alu_out    (alu_out),
        .done       (done),
        .jump       (jump),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: full-width subtraction and an independent signed compare
    function automatic exp_t model_cmp(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [15:0] d;
        logic        z, n, cy, v, lt;
        d  = a - b;
        z  = (d == 16'h0000);
        n  = d[15];
        cy = (a >= b);
`ifdef CMP_SIGNED_OVF_EN
        v  = (a[15] != b[15]) && (d[15] != a[15]);
        lt = ($signed(a) < $signed(b));
`else
        v  = 1'b0;
        lt = n;
`endif
        case (c)
            4'd0:    e.jump = z;
            4'd1:    e.jump = !z;
            4'd2:    e.jump = !z && !lt;
            4'd3:    e.jump = lt;
            4'd4:    e.jump = (a == 16'h0000);
            4'd5:    e.jump = a[15];
            4'd6:    e.jump = (a == 16'hFFFF);
            4'd7:    e.jump = cy;
            4'd8:    e.jump = !cy;
            4'd9:    e.jump = cy && !z;
            4'd10:   e.jump = 1'b1;
            default: e.jump = 1'b0;
        endcase
        e.flags = {z, n, cy, v};
        e.cyc   = 0;
        return e;
    endfunction

    // Called and returns at posedge+2
    task automatic wait_ready();
        int w = 0;
        while (ready !== 1'b1 && w < 50) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    // use_model=0 takes the literal expectation xj/xf; push=0 issues an op
    // that is expected never to complete.
    task automatic do_op(input logic sub, input logic ri, input logic [3:0] c,
                         input logic [15:0] a, input logic [15:0] bs, input logic [15:0] bi,
                         input logic [15:0] alu, input bit use_model,
                         input logic xj, input logic [3:0] xf, input bit push);
        exp_t e;
        wait_ready();
        cmp_or_sub = sub;
        r_or_i     = ri;
        cond       = c;
        rd_data    = a;
        rs_data    = bs;
        n_imm      = bi;
        alu_out    = alu;
        start      = 1'b1;
        if (sub) begin
            e.jump  = use_model ? (alu == 16'h0000) : xj;
            e.flags = use_model ? sb_flags : xf;
            e.cyc   = cyc + 1 + 2;
        end else begin
            e = model_cmp(c, a, ri ? bi : bs);
            if (!use_model) begin
                e.jump  = xj;
                e.flags = xf;
            end
            e.cyc = cyc + 1 + 5;
        end
        if (push) begin
            sb.push_back(e);
            sb_flags = e.flags;
        end
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_jump  = 1'b0;
            hold_flags = 4'b0000;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("jump", 32'(jump), 32'(mon_e.jump));
                chk("flags", 32'(flags), 32'(mon_e.flags));
                hold_jump  = mon_e.jump;
                hold_flags = mon_e.flags;
            end
        end else begin
            chk("jump_hold", 32'(jump), 32'(hold_jump));
            chk("flags_hold", 32'(flags), 32'(hold_flags));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        he;
        int          t0;
        int          w;
        logic [15:0] ra, rbs, rbi, ralu;
        logic [3:0]  rc;
        logic        rri;

        reset = 1'b1; start = 1'b0; r_or_i = 1'b0; cmp_or_sub = 1'b0; cond = 4'd0;
        rd_data = '0; rs_data = '0; n_imm = '0; alu_out = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_jump", 32'(jump), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #2;

        // EQ
        do_op(1'b0, 1'b0, 4'd0, 16'h1234, 16'h1234, 16'h0000, 16'h0, 1'b0, 1'b1, 4'b1010, 1'b1);
        // LT / LTU with immediate -1; rs_data differs so the mux is exercised
        do_op(1'b0, 1'b1, 4'd3, 16'h0001, 16'h0005, 16'hFFFF, 16'h0, 1'b0, 1'b0, 4'b0000, 1'b1);
        do_op(1'b0, 1'b1, 4'd8, 16'h0001, 16'h0005, 16'hFFFF, 16'h0, 1'b0, 1'b1, 4'b0000, 1'b1);
        // Signed overflow: 0x8000 - 1
`ifdef CMP_SIGNED_OVF_EN
        do_op(1'b0, 1'b0, 4'd3, 16'h8000, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 1'b1, 4'b0011, 1'b1);
        // SUB mode keeps the previous flags; cond is ignored
        do_op(1'b1, 1'b0, 4'd11, 16'h0003, 16'h0004, 16'h0, 16'h0000, 1'b0, 1'b1, 4'b0011, 1'b1);
        do_op(1'b1, 1'b0, 4'd10, 16'h0003, 16'h0004, 16'h0, 16'h0040, 1'b0, 1'b0, 4'b0011, 1'b1);
`else
        do_op(1'b0, 1'b0, 4'd3, 16'h8000, 16'h0001, 16'hFFFF, 16'h0, 1'b0, 1'b0, 4'b0010, 1'b1);
        do_op(1'b1, 1'b0, 4'd11, 16'h0003, 16'h0004, 16'h0, 16'h0000, 1'b0, 1'b1, 4'b0010, 1'b1);
        do_op(1'b1, 1'b0, 4'd10, 16'h0003, 16'h0004, 16'h0, 16'h0040, 1'b0, 1'b0, 4'b0010, 1'b1);
`endif

        // start held high: accepts at +1, +7, +13; starts during RUN ignored
        wait_ready();
        t0 = cyc;
        rd_data = 16'h0005; rs_data = 16'h0003; n_imm = 16'h0000; r_or_i = 1'b0;
        cmp_or_sub = 1'b0; cond = 4'd2; alu_out = 16'h0;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            he.cyc   = t0 + 6 + 6 * k;
            he.jump  = 1'b1;
            he.flags = 4'b0010;
            sb.push_back(he);
        end
        sb_flags = 4'b0010;
        repeat (15) @(posedge clk);
        #2;
        start = 1'b0;

        // Reset two cycles after accept drops the op
        do_op(1'b0, 1'b0, 4'd10, 16'h1234, 16'h0001, 16'h0, 16'h0, 1'b1, 1'b0, 4'b0000, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb_flags = 4'b0000;
        @(negedge clk);
        chk("rst_run_ready", 32'(ready), 32'd1);
        chk("rst_run_done", 32'(done), 32'd0);
        chk("rst_run_jump", 32'(jump), 32'd0);
        chk("rst_run_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #2;
        // NE after reset: 0x00FF - 0x0F00 = 0xF1FF
        do_op(1'b0, 1'b0, 4'd1, 16'h00FF, 16'h0F00, 16'h0, 16'h0, 1'b0, 1'b1, 4'b0100, 1'b1);

        // Randomised ops checked against the model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 16'h0000;
                1:       ra = 16'hFFFF;
                2:       ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            rbs  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rbi  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rri  = 1'($urandom_range(0, 1));
            rc   = 4'($urandom_range(0, 15));
            ralu = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
            do_op(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0, rri, rc, ra, rbs, rbi, ralu,
                  1'b1, 1'b0, 4'b0000, 1'b1);
        end

        w = 0;
        while (sb.size() > 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
